axi2apb_arb: RTL and testbench
==============================

# axi2apb_arb

Request scheduler for the AXI-Lite to APB bridge: arbitrates between the AXI-Lite read channel (AR) and write channels (AW+W) and issues one command at a time to the APB transfer engine. Address-window decode is done before issue, and a watchdog aborts stalled APB transfers. The block returns the R/B responses. It sits between the AXI-Lite slave port and the APB master engine inside `axi2apb_top`.

## Interface
- `BASE_HI`, 16'hA001: required value of address bits [31:16]
- `TIMEOUT`, 15: maximum WAIT cycles before abort (1..255)
- `RD_STREAK`, 4: maximum consecutive read grants while a write is pending (1..15)

Ports:
- `ACLK` in 1: single clock
- `ARESETn` in 1: reset, synchronous, active-low
- `ARADDR` in 32; `ARVALID` in 1; `ARREADY` out 1
- `AWADDR` in 32; `AWVALID` in 1; `AWREADY` out 1
- `WDATA` in 32; `WVALID` in 1; `WREADY` out 1
- `RDATA` out 32; `RRESP` out 2; `RVALID` out 1; `RREADY` in 1
- `BRESP` out 2; `BVALID` out 1; `BREADY` in 1
- `cmd_valid` out 1; `cmd_write` out 1; `cmd_addr` out 16; `cmd_wdata` out 32: command to the APB engine
- `cmd_ready` in 1: engine accepts the command
- `cmd_done` in 1; `cmd_rdata` in 32; `cmd_slverr` in 1: completion pulse and result
- `cmd_abort` out 1: one-cycle pulse on timeout; the engine drops PSEL/PENABLE

## Operation
- States: IDLE, ISSUE, WAIT, RSP_R, RSP_B.
- **IDLE:**
  - A read candidate exists when ARVALID=1.
  - A write candidate exists when AWVALID=1 and WVALID=1. AW without W, or W without AW, is not a candidate.
  - If both candidates exist, read wins, unless streak==RD_STREAK, in which case write wins.
- **Grant:** ARREADY, or AWREADY together with WREADY, is driven combinationally high in IDLE for the winner only. The handshake edge latches the address, the write data and the direction.
- **Streak counter:**
  - Increments on a read grant while a write candidate exists.
  - Clears on a write grant.
  - Clears on a read grant with no write candidate.
- **Decode:** at the handshake, if addr[31:16] != BASE_HI, the block goes directly to RSP_R/RSP_B with resp=SLVERR (2'b10) and RDATA=0. No command is issued.
- **ISSUE:**
  - cmd_valid=1. cmd_addr=addr[15:0]. cmd_write and cmd_wdata are held stable.
  - On cmd_valid and cmd_ready, go to WAIT.
  - The watchdog counter clears at ISSUE entry and counts every ISSUE/WAIT cycle.
- **WAIT:**
  - cmd_done=1: latch cmd_rdata for reads. resp=OKAY, or SLVERR if cmd_slverr=1. Go to RSP_R/RSP_B.
  - Counter reaches TIMEOUT without cmd_done: pulse cmd_abort, resp=SLVERR, RDATA=0, go to the response state.
  - cmd_done arriving in the same cycle as the timeout: cmd_done wins and there is no abort.
- **RSP_R / RSP_B:** RVALID/BVALID are held with stable data until RREADY/BREADY, then the block returns to IDLE. No new grant is made while a response is pending.
- EXOKAY and DECERR are never generated.

## Timing
- Reset values: all outputs 0, state IDLE, streak 0, watchdog 0.
- Reset asserted mid-transfer:
  - The block goes to IDLE at the next edge.
  - The pending command and response are discarded.
  - cmd_abort is not pulsed.
- Latency for an AR handshake at edge N with cmd_ready=1 and cmd_done at N+2:
  - cmd_valid is high in cycle N..N+1.
  - RVALID rises after edge N+2.
  - The minimum AR-to-RVALID latency is 2 cycles.
  - The earliest next grant is the cycle after the R handshake.
- Decode failure: RVALID/BVALID rises after the handshake edge (1 cycle).
- Timeout:
  - cmd_abort is high during cycle TIMEOUT after ISSUE entry.
  - RVALID/BVALID rises on the following edge.
- Handshake rules:
  - The ready signals never depend on RREADY/BREADY.
  - VALID signals on R/B never drop without a handshake.

## Structure
- Package `axi2apb_pkg` holds:
  - Response codes OKAY/EXOKAY/SLVERR/DECERR.
  - The state encoding.
  - The AXI4 address/data widths and the APB address width.
  - Shared by the bridge top and the engine.
- Sub-module `axi2apb_wdt`: 8-bit watchdog with clear, enable and `expired` output.

## Test plan
- **Single read:** ARADDR=A0010010; engine returns cmd_rdata=12345678 with slverr=0 → cmd_addr=0010, RDATA=12345678, RRESP=00.
- **Simultaneous AR and AW+W:** read 0xA0010004 and write 0xA0010008 data DEADBEEF → read issued first, then write. BRESP=00, cmd_wdata=DEADBEEF.
- **Starvation guard:** ARVALID held with 6 back-to-back reads and a write pending throughout → write is granted after exactly RD_STREAK=4 reads.
- **Timeout:** read 0xA0010020 and never assert cmd_done → cmd_abort pulse after 15 cycles, then RRESP=10 and RDATA=0. Repeat for a write: BRESP=10.
- **Decode error:** ARADDR=B0011000 and AWADDR=C0011000 → no cmd_valid, SLVERR returned within 1 cycle.
- **Reset mid-WAIT, and AW without W:** ARESETn=0 mid-WAIT → all outputs 0 next cycle. Then AWVALID alone for 5 cycles → AWREADY stays 0.

Source files
------------

// File: rtl/axi2apb_pkg.sv
// Shared types for the AXI-Lite to APB bridge: bus widths, response codes,
// scheduler state encoding and the latched command.
package axi2apb_pkg;
   localparam int AXI_AW = 32;
   localparam int AXI_DW = 32;
   localparam int APB_AW = 16;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RSP_R,
      S_RSP_B
   } state_e;

   typedef struct packed {
      logic              write;
      logic [APB_AW-1:0] addr;
      logic [AXI_DW-1:0] wdata;
   } cmd_t;

   // Upper address bits must match the bridge window.
   function automatic logic addr_hit(input logic [AXI_AW-1:0] addr, input logic [15:0] base_hi);
      return addr[AXI_AW-1:APB_AW] == base_hi;
   endfunction
endpackage

// File: rtl/axi2apb_arb_if.sv
// AXI-Lite slave channels plus the command/completion link to the APB engine.
// slave = scheduler side, master = AXI master / engine side.
interface axi2apb_arb_if;
   import axi2apb_pkg::*;

   logic [AXI_AW-1:0] ARADDR;
   logic              ARVALID, ARREADY;
   logic [AXI_AW-1:0] AWADDR;
   logic              AWVALID, AWREADY;
   logic [AXI_DW-1:0] WDATA;
   logic              WVALID, WREADY;
   logic [AXI_DW-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RVALID, RREADY;
   logic [1:0]        BRESP;
   logic              BVALID, BREADY;
   logic              cmd_valid, cmd_write, cmd_ready;
   logic [APB_AW-1:0] cmd_addr;
   logic [AXI_DW-1:0] cmd_wdata, cmd_rdata;
   logic              cmd_done, cmd_slverr, cmd_abort;

   modport slave (
      input  ARADDR, ARVALID, AWADDR, AWVALID, WDATA, WVALID, RREADY, BREADY,
      input  cmd_ready, cmd_done, cmd_rdata, cmd_slverr,
      output ARREADY, AWREADY, WREADY, RDATA, RRESP, RVALID, BRESP, BVALID,
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_abort
   );

   modport master (
      output ARADDR, ARVALID, AWADDR, AWVALID, WDATA, WVALID, RREADY, BREADY,
      output cmd_ready, cmd_done, cmd_rdata, cmd_slverr,
      input  ARREADY, AWREADY, WREADY, RDATA, RRESP, RVALID, BRESP, BVALID,
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_abort
   );
endinterface

// File: rtl/axi2apb_wdt.sv
// 8-bit transfer watchdog: cleared when a command is granted, counts while a
// transfer is outstanding, flags the TIMEOUT-th counted cycle.
module axi2apb_wdt #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)                  cnt <= '0;
      else if (clr)                cnt <= '0;
      else if (en && cnt != 8'hFF) cnt <= cnt + 8'd1;
   end

   // cnt holds k-1 during the k-th cycle after the grant edge
   assign expired = (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/axi2apb_arb.sv
// AR vs AW+W scheduler for the AXI-Lite to APB bridge: window decode, one
// command in flight, watchdog abort, R/B response return.
module axi2apb_arb
   import axi2apb_pkg::*;
#(
   parameter logic [15:0] BASE_HI   = 16'hA001,
   parameter int          TIMEOUT   = 15,
   parameter int          RD_STREAK = 4
) (
   input logic          ACLK,
   input logic          ARESETn,
   axi2apb_arb_if.slave bus
);
   state_e            state;
   logic [3:0]        streak;
   cmd_t              cmd_q;
   logic              cmd_valid_q, rvalid_q, bvalid_q;
   logic [AXI_DW-1:0] rdata_q;
   resp_e             rresp_q, bresp_q;

   logic              rd_cand, wr_cand, rd_win, wr_win, grant, dec_hit;
   logic [AXI_AW-1:0] gnt_addr;
   logic              wdt_expired, in_xfer, done_ok, abort, finish;
   resp_e             fin_resp;
   logic [AXI_DW-1:0] fin_rdata;

   assign rd_cand  = bus.ARVALID;
   assign wr_cand  = bus.AWVALID & bus.WVALID;
   // reads are preferred until the streak limit lets a waiting write through
   assign wr_win   = wr_cand & (~rd_cand | (streak == 4'(RD_STREAK)));
   assign rd_win   = rd_cand & ~wr_win;
   assign grant    = ARESETn & (state == S_IDLE) & (rd_win | wr_win);
   assign gnt_addr = wr_win ? bus.AWADDR : bus.ARADDR;
   assign dec_hit  = addr_hit(gnt_addr, BASE_HI);

   assign bus.ARREADY = grant & rd_win;
   assign bus.AWREADY = grant & wr_win;
   assign bus.WREADY  = grant & wr_win;

   // a completion in the expiry cycle beats the abort
   assign in_xfer   = (state == S_ISSUE) | (state == S_WAIT);
   assign done_ok   = (state == S_WAIT) & bus.cmd_done;
   assign abort     = in_xfer & wdt_expired & ~done_ok;
   assign finish    = done_ok | abort;
   assign fin_resp  = (done_ok & ~bus.cmd_slverr) ? RESP_OKAY : RESP_SLVERR;
   assign fin_rdata = done_ok ? bus.cmd_rdata : '0;

   axi2apb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk     (ACLK),
      .rst_n   (ARESETn),
      .clr     (grant),
      .en      (in_xfer),
      .expired (wdt_expired)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state       <= S_IDLE;
         streak      <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= RESP_OKAY;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
      end else begin
         unique case (state)
            S_IDLE: if (grant) begin
               streak      <= (rd_win & wr_cand) ? streak + 4'd1 : 4'd0;
               cmd_q.write <= wr_win;
               cmd_q.addr  <= gnt_addr[APB_AW-1:0];
               if (wr_win) cmd_q.wdata <= bus.WDATA;
               if (!dec_hit) begin
                  if (wr_win) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_SLVERR;
                     state    <= S_RSP_B;
                  end else begin
                     rvalid_q <= 1'b1;
                     rresp_q  <= RESP_SLVERR;
                     rdata_q  <= '0;
                     state    <= S_RSP_R;
                  end
               end else begin
                  cmd_valid_q <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE, S_WAIT: begin
               if (finish) begin
                  cmd_valid_q <= 1'b0;
                  if (cmd_q.write) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= fin_resp;
                     state    <= S_RSP_B;
                  end else begin
                     rvalid_q <= 1'b1;
                     rresp_q  <= fin_resp;
                     rdata_q  <= fin_rdata;
                     state    <= S_RSP_R;
                  end
               end else if (state == S_ISSUE && bus.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  state       <= S_WAIT;
               end
            end
            S_RSP_R: if (bus.RREADY) begin
               rvalid_q <= 1'b0;
               state    <= S_IDLE;
            end
            S_RSP_B: if (bus.BREADY) begin
               bvalid_q <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_write = cmd_q.write;
   assign bus.cmd_addr  = cmd_q.addr;
   assign bus.cmd_wdata = cmd_q.wdata;
   assign bus.cmd_abort = ARESETn & abort;
   assign bus.RDATA     = rdata_q;
   assign bus.RRESP     = rresp_q;
   assign bus.RVALID    = rvalid_q;
   assign bus.BRESP     = bresp_q;
   assign bus.BVALID    = bvalid_q;
endmodule

// File: tb/tb_axi2apb_arb.sv
// Directed + randomized bench for axi2apb_arb; the bench plays both the AXI
// master and the APB engine and predicts every response from the block rules.
module tb_axi2apb_arb;
   localparam logic [15:0] BASE_HI   = 16'hA001;
   localparam int          TIMEOUT   = 15;
   localparam int          RD_STREAK = 4;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   axi2apb_arb_if bus();

   axi2apb_arb #(.BASE_HI(BASE_HI), .TIMEOUT(TIMEOUT), .RD_STREAK(RD_STREAK)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_bad = 0;
   int m_streak = 0;  // model: reads granted in a row over a waiting write

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ":ctl"}, 32'({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID,
                                bus.cmd_valid, bus.cmd_write, bus.cmd_abort, bus.RRESP, bus.BRESP}), 32'd0);
      check({tag, ":addr"}, 32'(bus.cmd_addr), 32'd0);
      check({tag, ":rdata"}, bus.RDATA, 32'd0);
      check({tag, ":wdata"}, bus.cmd_wdata, 32'd0);
   endtask

   // One transaction from grant to response handshake. The engine accepts in
   // cycle rdy_c and completes in cycle done_c (counted from the grant edge);
   // the loser of the arbitration stays asserted throughout.
   task automatic txn(input bit rd_on, input bit wr_on, input logic [31:0] ar_a, input logic [31:0] aw_a,
                      input logic [31:0] wd, input int rdy_c, input int done_c, input bit slv,
                      input logic [31:0] rd, input int rr_wait, input string tag, output bit was_wr);
      bit w, bad, fin;
      logic [31:0] a, exp_rd;
      logic [1:0]  exp_resp;
      bus.ARADDR  = ar_a;  bus.ARVALID = rd_on;
      bus.AWADDR  = aw_a;  bus.AWVALID = wr_on;
      bus.WDATA   = wd;    bus.WVALID  = wr_on;
      w = wr_on && (!rd_on || m_streak == RD_STREAK);
      if (w) m_streak = 0;
      else if (wr_on) m_streak++;
      else m_streak = 0;
      a = w ? aw_a : ar_a;
      #1;
      check({tag, ":grant"}, 32'({bus.ARREADY, bus.AWREADY, bus.WREADY}), w ? 32'd3 : 32'd4);
      was_wr = bus.AWREADY;
      tick();
      if (w) begin bus.AWVALID = 1'b0; bus.WVALID = 1'b0; end
      else bus.ARVALID = 1'b0;
      bad = (a[31:16] != BASE_HI);
      exp_resp = 2'b10;
      exp_rd = 32'd0;
      if (bad) check({tag, ":dec_nocmd"}, 32'(bus.cmd_valid), 32'd0);
      else begin
         fin = 1'b0;
         for (int c = 1; c <= TIMEOUT && !fin; c++) begin
            check({tag, ":cmd_valid"}, 32'(bus.cmd_valid), 32'(c <= rdy_c));
            if (c <= rdy_c) begin
               check({tag, ":cmd_addr"}, 32'(bus.cmd_addr), 32'(a[15:0]));
               check({tag, ":cmd_write"}, 32'(bus.cmd_write), 32'(w));
               if (w) check({tag, ":cmd_wdata"}, bus.cmd_wdata, wd);
            end
            check({tag, ":busy"}, 32'({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID}), 32'd0);
            bus.cmd_ready  = (c == rdy_c);
            bus.cmd_done   = (c == done_c);
            bus.cmd_slverr = slv;
            bus.cmd_rdata  = (c == done_c) ? rd : $urandom;
            #1;
            check({tag, ":abort"}, 32'(bus.cmd_abort), 32'((c == TIMEOUT) && (c != done_c)));
            if (c == done_c) begin
               fin = 1'b1;
               exp_resp = slv ? 2'b10 : 2'b00;
               exp_rd = rd;
            end else if (c == TIMEOUT) fin = 1'b1;
            tick();
            bus.cmd_ready = 1'b0;
            bus.cmd_done  = 1'b0;
         end
      end
      for (int k = 0; k <= rr_wait; k++) begin
         check({tag, ":rsp_valid"}, 32'({bus.RVALID, bus.BVALID}), w ? 32'd1 : 32'd2);
         if (w) check({tag, ":bresp"}, 32'(bus.BRESP), 32'(exp_resp));
         else begin
            check({tag, ":rresp"}, 32'(bus.RRESP), 32'(exp_resp));
            check({tag, ":rdata"}, bus.RDATA, exp_rd);
         end
         bus.RREADY = w ? 1'($urandom_range(0, 1)) : (k == rr_wait);
         bus.BREADY = w ? (k == rr_wait) : 1'($urandom_range(0, 1));
         #1;
         check({tag, ":no_grant"}, 32'({bus.ARREADY, bus.AWREADY, bus.WREADY}), 32'd0);
         tick();
      end
      bus.RREADY = 1'b0; bus.BREADY = 1'b0;
      bus.ARVALID = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      check({tag, ":rsp_done"}, 32'({bus.RVALID, bus.BVALID}), 32'd0);
   endtask

   initial begin
      bit ww, wdone;
      int nr, pos;
      bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.AWADDR = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WVALID = 1'b0; bus.RREADY = 1'b0; bus.BREADY = 1'b0;
      bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.cmd_rdata = '0; bus.cmd_slverr = 1'b0;
      ARESETn = 1'b0;
      tick(); tick();
      check_zero("reset");
      ARESETn = 1'b1;
      tick();

      // single read, minimum latency
      txn(1, 0, 32'hA0010010, 32'h0, 32'h0, 1, 2, 0, 32'h12345678, 2, "rd1", ww);
      // simultaneous: read first, then the held write
      txn(1, 1, 32'hA0010004, 32'hA0010008, 32'hDEADBEEF, 1, 2, 0, 32'h0BADF00D, 0, "sim_r", ww);
      txn(0, 1, 32'h0, 32'hA0010008, 32'hDEADBEEF, 2, 4, 0, 32'h0, 1, "sim_w", ww);
      // engine error, write side
      txn(0, 1, 32'h0, 32'hA001_00F0, 32'h5A5A5A5A, 1, 3, 1, 32'h0, 0, "wr_slverr", ww);

      // starvation guard: six reads and one write all pending
      nr = 6; wdone = 1'b0; pos = -1;
      for (int i = 0; i < 7; i++) begin
         txn(nr > 0, !wdone, 32'hA0010100 + 32'(4 * i), 32'hA0010200, 32'h13579BDF,
             1, 2, 0, 32'h1000 + 32'(i), 0, "starve", ww);
         if (ww) begin wdone = 1'b1; pos = i; end
         else nr--;
      end
      check("starve:write_slot", 32'(pos), 32'(RD_STREAK));

      // watchdog: read and write never completed, then completion on the last cycle
      txn(1, 0, 32'hA0010020, 32'h0, 32'h0, 1, 99, 0, 32'h0, 1, "tmo_rd", ww);
      txn(0, 1, 32'h0, 32'hA0010024, 32'hFEEDFACE, 1, 99, 0, 32'h0, 0, "tmo_wr", ww);
      txn(1, 0, 32'hA0010028, 32'h0, 32'h0, 99, 99, 0, 32'h0, 0, "tmo_issue", ww);
      txn(1, 0, 32'hA0010040, 32'h0, 32'h0, 1, TIMEOUT, 0, 32'hCAFEF00D, 0, "done_at_tmo", ww);

      // decode errors
      txn(1, 0, 32'hB0011000, 32'h0, 32'h0, 1, 2, 0, 32'h0, 1, "dec_rd", ww);
      txn(0, 1, 32'h0, 32'hC0011000, 32'h11111111, 1, 2, 0, 32'h0, 0, "dec_wr", ww);

      // reset mid-WAIT
      bus.ARADDR = 32'hA0010030; bus.ARVALID = 1'b1;
      #1;
      check("rst:grant", 32'(bus.ARREADY), 32'd1);
      tick();
      bus.ARVALID = 1'b0; m_streak = 0;
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      tick();
      ARESETn = 1'b0;
      tick();
      check_zero("rst_mid");
      ARESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst:dropped", 32'({bus.RVALID, bus.BVALID, bus.cmd_valid, bus.cmd_abort}), 32'd0);
      end

      // AW without W, then W without AW: never a candidate
      bus.AWADDR = 32'hA0010050; bus.AWVALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("aw_only", 32'({bus.ARREADY, bus.AWREADY, bus.WREADY}), 32'd0);
         tick();
      end
      bus.AWVALID = 1'b0; bus.WDATA = 32'h22222222; bus.WVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("w_only", 32'({bus.ARREADY, bus.AWREADY, bus.WREADY}), 32'd0);
         tick();
      end
      bus.WVALID = 1'b0;

      // randomized mix against the model
      for (int i = 0; i < 40; i++) begin
         bit ro, wo;
         int rc, dc;
         logic [31:0] ra, wa;
         ro = 1'($urandom_range(0, 1));
         wo = 1'($urandom_range(0, 1));
         if (!ro && !wo) ro = 1'b1;
         ra = {($urandom_range(0, 5) == 0) ? 16'hB001 : BASE_HI, 16'($urandom)};
         wa = {($urandom_range(0, 5) == 0) ? 16'h0001 : BASE_HI, 16'($urandom)};
         rc = $urandom_range(1, 3);
         dc = ($urandom_range(0, 7) == 0) ? 99 : rc + 1 + $urandom_range(0, 4);
         txn(ro, wo, ra, wa, $urandom, rc, dc, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), "rand", ww);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
